// File: rtl/uart_prog_loader.sv
// UART 8N1 program loader: packs bytes MSB-first into 32-bit words
// and writes them to instruction memory until the terminator arrives.
module uart_prog_loader #(
  parameter int          CLKS_PER_BIT = 86,
  parameter int          ADDR_W       = 14,
  parameter logic [31:0] END_WORD     = 32'h00000FFF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rx_i,
  output logic              prog_we_o,
  output logic [ADDR_W-1:0] prog_addr_o,
  output logic [31:0]       prog_wdata_o,
  output logic              prog_done_o,
  output logic              frame_err_o,
  output logic              overflow_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HI
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        rx_sync;
  logic              rx_s;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        sh_q, sh_d;
  logic              bv_q, bv_d;
  logic              ferr_d;
  logic [1:0]        byte_idx_q;
  logic [23:0]       word_q;
  logic [31:0]       word_nx;
  logic [ADDR_W-1:0] addr_q;
  logic              wrap_q;

  assign rx_s    = rx_sync[1];
  assign word_nx = {word_q, sh_q};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_sync <= 2'b11;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      bv_q    <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[0], rx_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      bv_q    <= bv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    sh_d    = sh_q;
    bv_d    = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d       = '0;
          sh_d[bit_q] = rx_s;
          bit_d       = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            bv_d    = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_HI;
          end
        end
      end
      S_WAIT_HI: begin
        cnt_d = '0;
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // loading finished: receiver parks until reset
    if (prog_done_o) state_d = S_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      byte_idx_q   <= '0;
      word_q       <= '0;
      addr_q       <= '0;
      wrap_q       <= 1'b0;
      prog_we_o    <= 1'b0;
      prog_addr_o  <= '0;
      prog_wdata_o <= '0;
      prog_done_o  <= 1'b0;
      frame_err_o  <= 1'b0;
      overflow_o   <= 1'b0;
    end else begin
      prog_we_o <= 1'b0;
      if (ferr_d) frame_err_o <= 1'b1;
      if (bv_q) begin
        word_q     <= word_nx[23:0];
        byte_idx_q <= byte_idx_q + 2'd1;
        if (byte_idx_q == 2'd3) begin
          if (word_nx == END_WORD) begin
            prog_done_o <= 1'b1;
          end else if (overflow_o || wrap_q) begin
            overflow_o <= 1'b1;
          end else begin
            prog_we_o    <= 1'b1;
            prog_addr_o  <= addr_q;
            prog_wdata_o <= word_nx;
            addr_q       <= addr_q + ADDR_W'(1);
            if (&addr_q) wrap_q <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: serial byte driver, word-level
// reference model and write scoreboard for two configurations.
`timescale 1ns/1ps
module tb_uart_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx0 = 1'b1;
  logic        rx1 = 1'b1;
  logic        we0, we1;
  logic [13:0] addr0;
  logic [1:0]  addr1;
  logic [31:0] data0, data1;
  logic        done0, done1, ferr0, ferr1, ovf0, ovf1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_prog_loader #(.CLKS_PER_BIT(86)) dut (
    .clk_i(clk), .rst_i(rst), .rx_i(rx0),
    .prog_we_o(we0), .prog_addr_o(addr0), .prog_wdata_o(data0),
    .prog_done_o(done0), .frame_err_o(ferr0), .overflow_o(ovf0)
  );

  uart_prog_loader #(.CLKS_PER_BIT(32), .ADDR_W(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .rx_i(rx1),
    .prog_we_o(we1), .prog_addr_o(addr1), .prog_wdata_o(data1),
    .prog_done_o(done1), .frame_err_o(ferr1), .overflow_o(ovf1)
  );

  logic [63:0] obs0[$], obs1[$], exp0[$], exp1[$];

  always @(negedge clk) begin
    if (we0) obs0.push_back({32'(addr0), data0});
    if (we1) obs1.push_back({32'(addr1), data1});
  end

  // reference model: word count, not an address register
  int          aw[2] = '{14, 2};
  int          m_idx[2];
  int          m_n[2];
  logic [31:0] m_word[2];
  bit          m_done[2], m_ovf[2], m_ferr[2];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  task automatic model_byte(input int s, input logic [7:0] b);
    logic [31:0] w;
    if (m_done[s]) return;
    w = m_word[s];
    w = {w[23:0], b};
    m_word[s] = w;
    m_idx[s]++;
    if (m_idx[s] == 4) begin
      m_idx[s] = 0;
      if (w == 32'h00000FFF) m_done[s] = 1'b1;
      else if (m_n[s] >= (1 << aw[s])) m_ovf[s] = 1'b1;
      else begin
        if (s == 0) exp0.push_back({32'(m_n[s]), w});
        else exp1.push_back({32'(m_n[s]), w});
        m_n[s]++;
      end
    end
  endtask

  task automatic drive(input int s, input logic v);
    if (s == 0) rx0 = v;
    else rx1 = v;
  endtask

  task automatic send_byte(input int s, input logic [7:0] b,
                           input bit stop_ok);
    int c;
    c = (s == 0) ? 86 : 32;
    drive(s, 1'b0);
    repeat (c + 10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drive(s, b[i]);
      repeat (c) @(negedge clk);
    end
    drive(s, stop_ok);
    repeat (c) @(negedge clk);
    drive(s, 1'b1);
    if (stop_ok) model_byte(s, b);
    else begin
      m_ferr[s] = 1'b1;
      repeat (c) @(negedge clk);
    end
  endtask

  task automatic send_word(input int s, input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(s, w[i*8 +: 8], 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx0 = 1'b1;
    rx1 = 1'b1;
    repeat (3) @(negedge clk);
    obs0.delete(); obs1.delete(); exp0.delete(); exp1.delete();
    for (int s = 0; s < 2; s++) begin
      m_idx[s] = 0; m_n[s] = 0; m_word[s] = '0;
      m_done[s] = 0; m_ovf[s] = 0; m_ferr[s] = 0;
    end
  endtask

  task automatic check_rst();
    chk("rst_we", {we1, we0}, 0);
    chk("rst_addr", {addr1, addr0}, 0);
    chk("rst_data", {data1, data0}, 0);
    chk("rst_flags", {done1, ferr1, ovf1, done0, ferr0, ovf0}, 0);
  endtask

  task automatic check_scn(input string tag, input int s);
    logic [63:0] o[$], e[$];
    repeat (4) @(negedge clk);
    if (s == 0) begin
      o = obs0; e = exp0;
      chk({tag, "_flags"}, {done0, ferr0, ovf0},
          {m_done[0], m_ferr[0], m_ovf[0]});
    end else begin
      o = obs1; e = exp1;
      chk({tag, "_flags"}, {done1, ferr1, ovf1},
          {m_done[1], m_ferr[1], m_ovf[1]});
    end
    chk({tag, "_nwr"}, o.size(), e.size());
    for (int i = 0; i < o.size() && i < e.size(); i++)
      chk({tag, "_wr"}, o[i], e[i]);
  endtask

  initial begin
    logic [31:0] w;
    do_reset();
    check_rst();
    rst = 1'b0;
    repeat (5) @(negedge clk);

    send_word(0, 32'hDEADBEEF);
    chk("t1_exp", exp0.size(), 1);
    check_scn("t1", 0);

    do_reset(); rst = 1'b0;
    send_word(0, 32'h00000013);
    send_word(0, 32'h00100093);
    send_word(0, 32'h00000FFF);
    send_word(0, 32'h12345678);
    check_scn("t2", 0);
    chk("t2_done", done0, 1);

    do_reset(); rst = 1'b0;
    rx0 = 1'b0;
    repeat (20) @(negedge clk);
    rx0 = 1'b1;
    repeat (200) @(negedge clk);
    check_scn("t3_glitch", 0);
    send_word(0, 32'h55667788);
    check_scn("t3", 0);

    do_reset(); rst = 1'b0;
    send_byte(0, 8'hA5, 1'b0);
    send_word(0, 32'h11223344);
    check_scn("t4", 0);
    chk("t4_ferr", ferr0, 1);

    do_reset(); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      w = $urandom();
      if (w == 32'h00000FFF) w = 32'h1;
      send_word(1, w);
    end
    check_scn("t5", 1);
    chk("t5_ovf", ovf1, 1);

    do_reset(); rst = 1'b0;
    send_byte(0, 8'hCA, 1'b1);
    send_byte(0, 8'hFE, 1'b1);
    do_reset();
    check_rst();
    rst = 1'b0;
    send_word(0, 32'h0BADF00D);
    check_scn("t6", 0);

    do_reset(); rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      logic [7:0] b;
      b = 8'($urandom());
      send_byte(0, b, 1'b1);
      repeat ($urandom_range(0, 15)) @(negedge clk);
    end
    check_scn("t7", 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
